// File: rtl/ras_link_detect.sv
// Call/return detector feeding the return address stack: decodes RISC-V link hints,
// drives RAS push/pop, and registers the instruction with its predicted return target.
module ras_link_detect #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Flush,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [XLEN-1:0] In_PC,
  input  logic [31:0]     In_Instr,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [XLEN-1:0] Out_PC,
  output logic            Out_IsCall,
  output logic            Out_IsRet,
  output logic [XLEN-1:0] Out_RetTarget,
  output logic            Out_RetTargetValid,
  output logic            RAS_PushEn,
  output logic            RAS_PopEn,
  output logic [XLEN-1:0] RAS_PushData,
  input  logic [XLEN-1:0] RAS_PeekData,
  input  logic            RAS_Empty,
  output logic            RAS_Stall
);

  typedef enum logic {
    IDLE,
    PUSH_PEND
  } state_t;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pend_data_q, pend_data_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic              out_is_call_q, out_is_call_d;
  logic              out_is_ret_q, out_is_ret_d;
  logic [XLEN-1:0]   out_ret_target_q, out_ret_target_d;
  logic              out_ret_target_valid_q, out_ret_target_valid_d;

  logic              is_comp;
  logic [6:0]        opcode;
  logic [4:0]        rd_32, rs1_32, rs1_c, rs2_c;
  logic [3:0]        funct4_c;
  logic              dec_push, dec_pop;
  logic [XLEN-1:0]   ret_addr;
  logic              accept;
  logic              push_en, pop_en;
  logic [XLEN-1:0]   push_data;
  logic              unused_instr_bits;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  assign is_comp  = (In_Instr[1:0] != 2'b11);
  assign opcode   = In_Instr[6:0];
  assign rd_32    = In_Instr[11:7];
  assign rs1_32   = In_Instr[19:15];
  assign rs1_c    = In_Instr[11:7];
  assign rs2_c    = In_Instr[6:2];
  assign funct4_c = In_Instr[15:12];
  assign unused_instr_bits = ^In_Instr[31:20];

  // C.JR/C.JALR live only in the C2 quadrant, so the quadrant bits gate compressed decode.
  always_comb begin
    dec_push = 1'b0;
    dec_pop  = 1'b0;
    if (!is_comp) begin
      if (opcode == OPC_JAL) begin
        dec_push = is_link(rd_32);
      end else if (opcode == OPC_JALR) begin
        if (is_link(rd_32) && !is_link(rs1_32)) begin
          dec_push = 1'b1;
        end else if (!is_link(rd_32) && is_link(rs1_32)) begin
          dec_pop = 1'b1;
        end else if (is_link(rd_32) && is_link(rs1_32)) begin
          dec_push = 1'b1;
          dec_pop  = (rd_32 != rs1_32);
        end
      end
    end else if ((In_Instr[1:0] == 2'b10) && (rs2_c == 5'd0) && (rs1_c != 5'd0)) begin
      if (funct4_c == 4'b1000) begin
        dec_pop = is_link(rs1_c);
      end else if (funct4_c == 4'b1001) begin
        dec_push = 1'b1;
        dec_pop  = (rs1_c == 5'd5);
      end
    end
  end

  assign ret_addr = In_PC + (is_comp ? XLEN'(2) : XLEN'(4));
  assign In_Ready = (state_q == IDLE) & (~out_valid_q | Out_Ready) & ~Flush;
  assign accept   = In_Valid & In_Ready;

  always_comb begin
    state_d     = state_q;
    pend_data_d = pend_data_q;
    push_en     = 1'b0;
    pop_en      = 1'b0;
    push_data   = ret_addr;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pop_en  = dec_pop;
          push_en = dec_push & ~dec_pop;
          // Coroutine: the push is deferred one cycle so PushEn and PopEn never overlap.
          if (dec_push && dec_pop) begin
            pend_data_d = ret_addr;
            state_d     = PUSH_PEND;
          end
        end
      end
      PUSH_PEND: begin
        push_data = pend_data_q;
        push_en   = ~Flush;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d            = out_valid_q;
    out_pc_d               = out_pc_q;
    out_is_call_d          = out_is_call_q;
    out_is_ret_d           = out_is_ret_q;
    out_ret_target_d       = out_ret_target_q;
    out_ret_target_valid_d = out_ret_target_valid_q;
    if (Flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d            = 1'b1;
      out_pc_d               = In_PC;
      out_is_call_d          = dec_push;
      out_is_ret_d           = dec_pop;
      out_ret_target_d       = dec_pop ? RAS_PeekData : '0;
      out_ret_target_valid_d = dec_pop & ~RAS_Empty;
    end else if (Out_Ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                <= IDLE;
      pend_data_q            <= '0;
      out_valid_q            <= 1'b0;
      out_pc_q               <= '0;
      out_is_call_q          <= 1'b0;
      out_is_ret_q           <= 1'b0;
      out_ret_target_q       <= '0;
      out_ret_target_valid_q <= 1'b0;
    end else begin
      state_q                <= state_d;
      pend_data_q            <= pend_data_d;
      out_valid_q            <= out_valid_d;
      out_pc_q               <= out_pc_d;
      out_is_call_q          <= out_is_call_d;
      out_is_ret_q           <= out_is_ret_d;
      out_ret_target_q       <= out_ret_target_d;
      out_ret_target_valid_q <= out_ret_target_valid_d;
    end
  end

  // RAS controls are masked while reset is asserted, independent of the inputs.
  assign RAS_PushEn         = push_en & ~rst;
  assign RAS_PopEn          = pop_en & ~rst;
  assign RAS_PushData       = push_data;
  assign RAS_Stall          = 1'b0;
  assign Out_Valid          = out_valid_q;
  assign Out_PC             = out_pc_q;
  assign Out_IsCall         = out_is_call_q;
  assign Out_IsRet          = out_is_ret_q;
  assign Out_RetTarget      = out_ret_target_q;
  assign Out_RetTargetValid = out_ret_target_valid_q;

endmodule
